// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive stage (LSB first, idle high).
// Synchronises din, samples each bit at mid-bit, and hands the received byte
// to the consumer on a valid/ack hold interface. Stop-bit errors and
// unacknowledged overwrites are reported as single-cycle pulses.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 279,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       ack,
    output logic [7:0] data_rx,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] state
);

    // Counter width; must hold CLKS_PER_BIT-1.
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_e;

    // Two-stage synchroniser; both stages rest at the idle-high line level.
    logic              sync1_q;
    logic              s_q;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [DATA_W-1:0] data_rx_q,   data_rx_d;
    logic              valid_q,     valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q,   overrun_d;

    // Bring the asynchronous serial line into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            s_q     <= 1'b1;
        end else begin
            sync1_q <= din;
            s_q     <= sync1_q;
        end
    end

    // Receiver state, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_rx_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_rx_q   <= data_rx_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, bit sampling and handshake; a byte load overrides an ack clear.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_rx_d   = data_rx_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (ack && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!s_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // Line back high at the start-bit midpoint means a glitch.
                    state_d = s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = s_q;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (s_q) begin
                        data_rx_d = shift_q;
                        valid_d   = 1'b1;
                        overrun_d = valid_q && !ack;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            BREAK: begin
                // Wait for the line to return high so a held-low line cannot retrigger.
                cnt_d = '0;
                idx_d = '0;
                if (s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign data_rx   = data_rx_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign state     = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: loopback bytes, back-to-back frames,
// glitch rejection, framing error with held-low line, overrun and
// coincident ack, and reset in the middle of a byte.
module tb_uart_receiver;

    localparam int CPB = 279;
    localparam int HB  = 139;
    // Edge-to-valid latency as observed by this bench; allowed 2654 +/- 1.
    localparam int LAT_MIN = 2653;
    localparam int LAT_MAX = 2655;
    // Din fall to STOP-sample edge as seen at the following negedge.
    localparam int STOP_OFS = 2 + 1 + HB + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       ack;
    logic [7:0] data_rx;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic [2:0] state;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .ack       (ack),
        .data_rx   (data_rx),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .state     (state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = -1;
    int fall_cyc = -1;
    int ack_cyc  = -1;
    int ov_cyc   = -1;
    int fe_cyc   = -1;
    int rise_cnt = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int auto_ack = -1;
    int start_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    logic       valid_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the negedge, then drive the automatic ack.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (valid && !valid_prev) begin
            rise_cnt++;
            rise_cyc  = cyc;
            rise_data = data_rx;
        end
        if (!valid && valid_prev) fall_cyc = cyc;
        valid_prev = valid;
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        if (overrun)   begin ov_cnt++; ov_cyc = cyc; end
        ack = 1'b0;
        if (auto_ack >= 0 && valid && (cyc - rise_cyc) == auto_ack) begin
            ack     = 1'b1;
            ack_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Transmit the first nbits of a frame; optional ack at a given offset from the start edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int nbits, input int ack_at);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < CPB; j++) begin
                tick();
                if (i == 0 && j == 0) start_cyc = cyc;
                din = frame[i];
                if ((i * CPB + j) == ack_at) begin
                    ack     = 1'b1;
                    ack_cyc = cyc;
                end
            end
        end
    endtask

    initial begin
        int r0;
        int f0;
        int o0;
        int k;
        logic seen_start;

        rst = 1'b0;
        din = 1'b1;
        ack = 1'b0;
        idle(3);
        check("rst_data_rx",   32'(data_rx),   32'h00);
        check("rst_valid",     32'(valid),     32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        check("rst_state",     32'(state),     32'h0);
        rst = 1'b1;
        idle(20);

        // Loopback 0xA5, ack ten cycles after valid.
        auto_ack = 10;
        send_byte(8'hA5, 1'b1, 10, -1);
        idle(20);
        check("a5_data",     32'(rise_data), 32'hA5);
        check("a5_rises",    32'(rise_cnt),  32'd1);
        check("a5_latency",  32'((rise_cyc - start_cyc) >= LAT_MIN && (rise_cyc - start_cyc) <= LAT_MAX), 32'd1);
        check("a5_clear",    32'(fall_cyc - ack_cyc), 32'd1);
        check("a5_valid_lo", 32'(valid),     32'h0);
        check("a5_hold",     32'(data_rx),   32'hA5);
        check("a5_no_fe",    32'(fe_cnt),    32'd0);
        check("a5_no_ov",    32'(ov_cnt),    32'd0);

        // Back-to-back 0x00 then 0xFF, acked promptly.
        auto_ack = 2;
        send_byte(8'h00, 1'b1, 10, -1);
        check("b2b_first",  32'(rise_data), 32'h00);
        send_byte(8'hFF, 1'b1, 10, -1);
        idle(20);
        check("b2b_second", 32'(rise_data), 32'hFF);
        check("b2b_rises",  32'(rise_cnt),  32'd3);
        check("b2b_no_err", 32'(fe_cnt + ov_cnt), 32'd0);
        check("b2b_valid",  32'(valid),     32'h0);

        // Short low pulse is rejected.
        auto_ack = -1;
        r0 = rise_cnt;
        seen_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            din = 1'b0;
            if (state == 3'd1) seen_start = 1'b1;
        end
        din = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
            if (state == 3'd1) seen_start = 1'b1;
        end while (state != 3'd0 && k < 142);
        check("glitch_started", 32'(seen_start), 32'h1);
        check("glitch_idle",    32'(state),      32'h0);
        idle(300);
        check("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);

        // Frame 0x3C with low stop bit and line held low.
        f0 = fe_cnt;
        r0 = rise_cnt;
        send_byte(8'h3C, 1'b0, 10, -1);
        idle(1000);
        check("fe_pulses",   32'(fe_cnt - f0),        32'd1);
        check("fe_timing",   32'(fe_cyc - start_cyc), 32'(STOP_OFS));
        check("fe_break",    32'(state),              32'h4);
        check("fe_data_kept",32'(data_rx),            32'hFF);
        check("fe_no_valid", 32'(rise_cnt - r0),      32'd0);
        din = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (state != 3'd0 && k < 10);
        check("fe_idle",       32'(state), 32'h0);
        check("fe_exit_delay", 32'(k),     32'd3);
        idle(20);

        // 0x11 then 0x22 with no ack: overwrite with one overrun pulse.
        o0 = ov_cnt;
        r0 = rise_cnt;
        send_byte(8'h11, 1'b1, 10, -1);
        send_byte(8'h22, 1'b1, 10, -1);
        idle(20);
        check("ov_data",    32'(data_rx),             32'h22);
        check("ov_valid",   32'(valid),               32'h1);
        check("ov_pulses",  32'(ov_cnt - o0),         32'd1);
        check("ov_timing",  32'(ov_cyc - start_cyc),  32'(STOP_OFS));
        check("ov_rises",   32'(rise_cnt - r0),       32'd1);
        tick();
        ack = 1'b1;
        tick();
        check("ov_ack_clear", 32'(valid), 32'h0);

        // Same pair with ack coincident with the second completion.
        o0 = ov_cnt;
        send_byte(8'h11, 1'b1, 10, -1);
        check("co_first",   32'(rise_data), 32'h11);
        send_byte(8'h22, 1'b1, 10, STOP_OFS - 1);
        idle(20);
        check("co_no_ov",   32'(ov_cnt - o0), 32'd0);
        check("co_valid",   32'(valid),       32'h1);
        check("co_data",    32'(data_rx),     32'h22);

        // Reset in the middle of 0x5A's data bits, then receive 0x96.
        f0 = fe_cnt;
        o0 = ov_cnt;
        send_byte(8'h5A, 1'b1, 5, -1);
        tick();
        rst = 1'b0;
        din = 1'b1;
        tick();
        rst = 1'b1;
        check("mid_rst_data",  32'(data_rx),   32'h00);
        check("mid_rst_valid", 32'(valid),     32'h0);
        check("mid_rst_state", 32'(state),     32'h0);
        check("mid_rst_fe",    32'(frame_err), 32'h0);
        check("mid_rst_ov",    32'(overrun),   32'h0);
        r0 = rise_cnt;
        idle(3000);
        check("abort_no_valid", 32'(rise_cnt - r0),          32'd0);
        check("abort_no_pulse", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
        auto_ack = 3;
        send_byte(8'h96, 1'b1, 10, -1);
        idle(20);
        check("post_rst_data",    32'(rise_data),       32'h96);
        check("post_rst_rises",   32'(rise_cnt - r0),   32'd1);
        check("post_rst_latency", 32'((rise_cyc - start_cyc) >= LAT_MIN && (rise_cyc - start_cyc) <= LAT_MAX), 32'd1);
        check("post_rst_no_err",  32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
        check("post_rst_valid",   32'(valid),           32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
